// File: rtl/pcm_pkg.sv
// Shared constants and FSM encoding for the PCM playback path.
package pcm_pkg;

   localparam int DAT_WIDTH = 16;
   // Signed zero; becomes the 50% duty point after offset-binary conversion.
   localparam int MIDSCALE  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

endpackage

// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: signed sample in, 1-bit density out.
module pdm_modulator
   import pcm_pkg::*;
#(
   parameter int DAT_WIDTH = pcm_pkg::DAT_WIDTH,
   parameter int PDM_DIV   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DAT_WIDTH-1:0] sample,
   output logic                 pdm_out
);

   localparam int DW = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;

   logic [DW-1:0]        div_q, div_d;
   logic [DAT_WIDTH-1:0] acc_q, acc_d;
   logic                 pdm_q, pdm_d;
   logic                 update;
   logic [DAT_WIDTH-1:0] u;
   logic [DAT_WIDTH:0]   sum;

   assign update = (div_q == DW'(PDM_DIV - 1));

   // Flipping the sign bit maps signed PCM onto an unsigned 0..2^W-1 density.
   assign u   = (enable ? sample : DAT_WIDTH'(MIDSCALE)) ^ {1'b1, {(DAT_WIDTH-1){1'b0}}};
   assign sum = {1'b0, acc_q} + {1'b0, u};

   always_comb begin
      div_d = div_q + 1'b1;
      acc_d = acc_q;
      pdm_d = pdm_q;
      if (update) begin
         div_d = '0;
         acc_d = sum[DAT_WIDTH-1:0];
         pdm_d = sum[DAT_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         acc_q <= '0;
         pdm_q <= 1'b0;
      end else begin
         div_q <= div_d;
         acc_q <= acc_d;
         pdm_q <= pdm_d;
      end
   end

   assign pdm_out = pdm_q;

endmodule

// File: rtl/pcm_fifo_player.sv
// PCM FIFO reader: fetches one sample per tick and drives a PDM output.
// Optional volume attenuation is compiled in with PCM_PLAYER_VOLUME_EN.
module pcm_fifo_player
   import pcm_pkg::*;
#(
   parameter int DAT_WIDTH  = pcm_pkg::DAT_WIDTH,
   parameter int SAMPLE_DIV = 3125,
   parameter int PDM_DIV    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 fifo_empty,
   input  logic [DAT_WIDTH-1:0] fifo_data,
`ifdef PCM_PLAYER_VOLUME_EN
   input  logic [3:0]           vol_shift,
`endif
   output logic                 fifo_rd,
   output logic [DAT_WIDTH-1:0] sample_out,
   output logic                 sample_valid,
   output logic                 underrun,
   output logic                 pdm_out
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CW-1:0]        cnt_q, cnt_d;
   state_e               state_q, state_d;
   logic                 settle_q, settle_d;
   logic                 fifo_rd_q, fifo_rd_d;
   logic [DAT_WIDTH-1:0] sample_q, sample_d;
   logic                 valid_q, valid_d;
   logic                 underrun_q, underrun_d;
   logic                 tick;
   logic [DAT_WIDTH-1:0] mod_sample;

   assign tick = enable && (cnt_q == CW'(SAMPLE_DIV - 1));

   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      state_d    = state_q;
      settle_d   = settle_q;
      fifo_rd_d  = 1'b0;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      underrun_d = underrun_q;
      if (!enable) begin
         cnt_d      = '0;
         state_d    = ST_IDLE;
         settle_d   = 1'b0;
         sample_d   = DAT_WIDTH'(MIDSCALE);
         underrun_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  valid_d = 1'b1;
                  if (!fifo_empty) begin
                     state_d   = ST_FETCH;
                     fifo_rd_d = 1'b1;
                     sample_d  = fifo_data;
                  end else begin
                     underrun_d = 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               state_d  = ST_SETTLE;
               settle_d = 1'b0;
            end
            // Two dead cycles let the FIFO pointer and empty flag catch up.
            ST_SETTLE: begin
               settle_d = 1'b1;
               if (settle_q) begin
                  state_d  = ST_IDLE;
                  settle_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         state_q    <= ST_IDLE;
         settle_q   <= 1'b0;
         fifo_rd_q  <= 1'b0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         settle_q   <= settle_d;
         fifo_rd_q  <= fifo_rd_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
      end
   end

   // A reset landing on the FETCH cycle must not consume the head word.
   assign fifo_rd      = fifo_rd_q & ~reset;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign underrun     = underrun_q;

`ifdef PCM_PLAYER_VOLUME_EN
   logic [3:0] vol_q, vol_d;

   always_comb begin
      vol_d = tick ? vol_shift : vol_q;
   end

   always_ff @(posedge clk) begin
      if (reset) vol_q <= '0;
      else       vol_q <= vol_d;
   end

   assign mod_sample = $signed(sample_q) >>> vol_q;
`else
   assign mod_sample = sample_q;
`endif

   pdm_modulator #(
      .DAT_WIDTH (DAT_WIDTH),
      .PDM_DIV   (PDM_DIV)
   ) u_pdm (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .sample  (mod_sample),
      .pdm_out (pdm_out)
   );

endmodule

// File: tb/tb_pcm_fifo_player.sv
// Directed bench for pcm_fifo_player with a FWFT FIFO model on the read side.
module tb_pcm_fifo_player;

   localparam int W  = 16;
   localparam int SD = 16;
   localparam int PD = 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b1;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_data = '0;
   logic [3:0]   vol_shift = '0;
   logic         fifo_rd;
   logic [W-1:0] sample_out;
   logic         sample_valid;
   logic         underrun;
   logic         pdm_out;

   logic [W-1:0] fifo_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           rd_count = 0;
   int           ones = 0;
   int           snap;
   logic         prev_rd = 1'b0;

   always #5 clk = ~clk;

   pcm_fifo_player #(
      .DAT_WIDTH  (W),
      .SAMPLE_DIV (SD),
      .PDM_DIV    (PD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
`ifdef PCM_PLAYER_VOLUME_EN
      .vol_shift    (vol_shift),
`endif
      .fifo_rd      (fifo_rd),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .underrun     (underrun),
      .pdm_out      (pdm_out)
   );

   task automatic update_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [W-1:0] d);
      fifo_q.push_back(d);
      update_fifo();
   endtask

   // Read side of the FIFO model; inputs only change just after posedge.
   always @(negedge clk) begin
      if (pdm_out) ones++;
      if (fifo_rd) begin
         n_checks++;
         assert (!fifo_empty && !prev_rd) else begin
            n_fail++;
            $error("FAIL rd_protocol: observed empty=%0b prev_rd=%0b expected 0/0", fifo_empty, prev_rd);
         end
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         rd_count++;
         update_fifo();
      end
      prev_rd = fifo_rd;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_checks++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_fetch(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (fifo_rd !== 1'b1 && n < 4 * SD);
      check(tag, {31'd0, fifo_rd}, 32'd1);
   endtask

   task automatic count_pdm(output int cnt);
      repeat (4) step();
      ones = 0;
      repeat (1024) step();
      cnt = ones;
   endtask

   initial begin
      int c;
      // 1: reset values, then the first fetch one clock after the first tick
      push(16'h1234);
      repeat (3) step();
      check("rst_sample", {16'd0, sample_out}, 32'h0);
      check("rst_valid", {31'd0, sample_valid}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check("rst_pdm", {31'd0, pdm_out}, 32'd0);
      check("rst_rd", {31'd0, fifo_rd}, 32'd0);
      reset = 1'b0;
      repeat (SD - 1) step();
      check("t1_pre_rd", {31'd0, fifo_rd}, 32'd0);
      step();
      check("t1_rd", {31'd0, fifo_rd}, 32'd1);
      check("t1_sample", {16'd0, sample_out}, 32'h1234);
      check("t1_valid", {31'd0, sample_valid}, 32'd1);
      step();
      check("t1_rd_once", {31'd0, fifo_rd}, 32'd0);
      check("t1_valid_once", {31'd0, sample_valid}, 32'd0);

      // 2: three queued words one tick apart, then an underrun
      push(16'h0001);
      push(16'h0002);
      push(16'h0003);
      snap = rd_count;
      for (int i = 1; i <= 3; i++) begin
         repeat (SD - 2) step();
         check("t2_gap_rd", {31'd0, fifo_rd}, 32'd0);
         step();
         check("t2_rd", {31'd0, fifo_rd}, 32'd1);
         check("t2_sample", {16'd0, sample_out}, i);
         step();
      end
      check("t2_rd_count", rd_count - snap, 32'd3);
      repeat (SD - 2) step();
      check("t2_no_underrun", {31'd0, underrun}, 32'd0);
      step();
      check("t2_underrun", {31'd0, underrun}, 32'd1);
      check("t2_ur_valid", {31'd0, sample_valid}, 32'd1);
      check("t2_ur_hold", {16'd0, sample_out}, 32'h0003);
      check("t2_ur_rd", {31'd0, fifo_rd}, 32'd0);
      check("t2_ur_count", rd_count - snap, 32'd3);

      // 3: modulator density at three levels
      push(16'h0000);
      wait_fetch("t3_fetch0");
      check("t3_sample0", {16'd0, sample_out}, 32'h0);
      check("t3_underrun_sticky", {31'd0, underrun}, 32'd1);
      count_pdm(c);
      check_range("t3_dens_0000", c, 511, 513);
      push(16'h4000);
      wait_fetch("t3_fetch4000");
      count_pdm(c);
      check_range("t3_dens_4000", c, 767, 769);
      push(16'h8000);
      wait_fetch("t3_fetch8000");
      count_pdm(c);
      check("t3_dens_8000", c, 32'd0);

      // 4: enable dropped during SETTLE, then re-enabled
      push(16'h0055);
      wait_fetch("t4_fetch");
      check("t4_sample", {16'd0, sample_out}, 32'h0055);
      push(16'h0066);
      step();
      enable = 1'b0;
      step();
      check("t4_dis_sample", {16'd0, sample_out}, 32'h0);
      check("t4_dis_underrun", {31'd0, underrun}, 32'd0);
      check("t4_dis_valid", {31'd0, sample_valid}, 32'd0);
      snap = rd_count;
      repeat (3 * SD) step();
      check("t4_dis_no_rd", rd_count - snap, 32'd0);
      enable = 1'b1;
      repeat (SD - 1) step();
      check("t4_en_pre_rd", {31'd0, fifo_rd}, 32'd0);
      step();
      check("t4_en_rd", {31'd0, fifo_rd}, 32'd1);
      check("t4_en_sample", {16'd0, sample_out}, 32'h0066);

      // 5: reset landing on the FETCH cycle
      push(16'h0077);
      wait_fetch("t5_fetch");
      reset = 1'b1;
      #1;
      check("t5_rd_blocked", {31'd0, fifo_rd}, 32'd0);
      step();
      check("t5_sample", {16'd0, sample_out}, 32'h0);
      check("t5_valid", {31'd0, sample_valid}, 32'd0);
      check("t5_underrun", {31'd0, underrun}, 32'd0);
      check("t5_pdm", {31'd0, pdm_out}, 32'd0);
      check("t5_rd", {31'd0, fifo_rd}, 32'd0);
      check("t5_word_kept", fifo_q.size(), 32'd1);
      reset = 1'b0;
      wait_fetch("t5_refetch");
      check("t5_refetch_sample", {16'd0, sample_out}, 32'h0077);

`ifdef PCM_PLAYER_VOLUME_EN
      // 6: attenuation only affects the modulator input
      vol_shift = 4'd2;
      push(16'h4000);
      wait_fetch("t6_fetch4000");
      check("t6_unattenuated", {16'd0, sample_out}, 32'h4000);
      count_pdm(c);
      check_range("t6_dens_4000_s2", c, 575, 577);
      vol_shift = 4'd1;
      push(16'hC000);
      wait_fetch("t6_fetchC000");
      count_pdm(c);
      check_range("t6_dens_C000_s1", c, 383, 385);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pcm_fifo_player.md
Name: pcm_fifo_player

Overview:
FIFO reader and audio back-end for the PCM audio path. Drains 16-bit signed PCM samples from the capture/playback FIFO at a fixed sample rate and drives a 1-bit first-order sigma-delta (PDM) output for an RC-filtered speaker/DAC pin. Sits on the read side of the FIFO, opposite the microphone capture writer.

Parameters:
DAT_WIDTH, 16, sample width; signed two's complement.
SAMPLE_DIV, 3125, clk cycles per sample tick (50 MHz / 16 kHz); minimum 8.
PDM_DIV, 16, clk cycles per modulator update; minimum 1.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high.
enable  in  1  playback enable; low = stop fetching and output midscale.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DAT_WIDTH  FIFO head word; first-word-fall-through, valid whenever fifo_empty=0.
fifo_rd  out  1  one-clk read strobe; consumes the head word.
sample_out  out  DAT_WIDTH  currently playing sample (signed).
sample_valid  out  1  one-clk pulse when sample_out updates.
underrun  out  1  sticky; set when a tick finds the FIFO empty. Cleared by reset or enable low.
pdm_out  out  1  sigma-delta bitstream.

Behaviour:
- Reset: fifo_rd=0, sample_out=0, sample_valid=0, underrun=0, pdm_out=0. Sample counter, PDM counter and accumulator = 0. FSM = IDLE.
- Sample counter counts 0..SAMPLE_DIV-1 while enable=1. Tick = the cycle it equals SAMPLE_DIV-1; it wraps to 0 on that cycle. With enable=0, the counter is held at 0.
- FSM states:
  - IDLE: on tick, if fifo_empty=0 go to FETCH. Otherwise set underrun, keep sample_out unchanged (hold last sample), pulse sample_valid, stay in IDLE.
  - FETCH: single cycle. fifo_rd=1, sample_out<=fifo_data, sample_valid=1. Go to SETTLE.
  - SETTLE: 2 cycles; no reads, ignores ticks (cannot occur since SAMPLE_DIV>=8). Return to IDLE. This covers the FIFO flag/pointer update latency.
- Latency: tick -> fifo_rd and sample_out update in the next clk (FETCH).
- fifo_rd is never asserted when fifo_empty=1 and is never asserted on two consecutive cycles.
- enable low, any state: FSM forces IDLE next cycle. No fifo_rd. sample_out<=0. underrun<=0. An in-flight FETCH cycle completes normally.
- Reset mid-FETCH: reset wins; fifo_rd=0 that cycle.
- PDM: every PDM_DIV clks, u = sample_out with MSB inverted (offset binary). acc[DAT_WIDTH:0] <= {1'b0, acc[DAT_WIDTH-1:0]} + u. pdm_out <= acc carry bit (next acc[DAT_WIDTH]). Accumulator wraps modulo 2^DAT_WIDTH with carry extracted; no saturation.
- Duty check: sample 0x0000 gives 50% density; 0x7FFF gives (2^16-1)/2^16; 0x8000 gives 0%.

Optional Feature:
Macro PCM_PLAYER_VOLUME_EN.
- Defined: adds input port vol_shift[3:0]. The sample fed to the modulator is sample_out >>> vol_shift (arithmetic shift), applied before the MSB inversion. vol_shift is sampled only on sample ticks. sample_out itself is unattenuated.
- Undefined: no port, no attenuation.

Decomposition:
- Shared package pcm_pkg: DAT_WIDTH default, FSM state encoding (IDLE=2'd0, FETCH=2'd1, SETTLE=2'd2), and midscale constant MIDSCALE=0.
- Natural sub-module: pdm_modulator. Contains the PDM divider, accumulator and pdm_out; inputs are sample and enable.

Test Plan:
1. Reset with enable=1 and FIFO holding 0x1234 -> all outputs 0. First tick (clk SAMPLE_DIV-1) -> next clk fifo_rd=1 for exactly 1 clk, sample_out=0x1234, sample_valid=1.
2. FIFO preloaded with 0x0001,0x0002,0x0003 -> exactly 3 fifo_rd pulses, SAMPLE_DIV apart. Outputs appear in order. The 4th tick with fifo_empty=1 -> underrun=1, sample_out stays 0x0003, no fifo_rd.
3. sample_out held at 0x0000, PDM_DIV=1, 1024 clks -> pdm_out ones count 512±1. At 0x4000 -> 768±1. At 0x8000 -> 0.
4. enable dropped during SETTLE -> no further fifo_rd, sample_out=0 and underrun=0 next clk. Re-enable -> first fetch after a full SAMPLE_DIV.
5. reset asserted on the FETCH cycle -> fifo_rd=0 that clk, all outputs at reset values next clk.
6. (PCM_PLAYER_VOLUME_EN) sample 0x4000, vol_shift=2 -> modulator input 0x1000, ones density 576/1024 ±1. Sample 0xC000 with shift 1 -> 0xE000.
